// File: rtl/asip_pkg.sv
`default_nettype none
// ============================================================================
// Package     : asip_pkg
// Description : Shared encodings for the vector ASIP front end. Contains the
//               op/inst opcode values, jump-condition (jmpF) codes, the
//               instruction-register field positions and the fetch/issue
//               state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package asip_pkg;

  // Instruction-register field positions
  localparam int OP_MSB    = 31;  // op    = IR[31:30]
  localparam int INST_MSB  = 29;  // inst  = IR[29:28]
  localparam int FLAGV_BIT = 27;  // flagV = IR[27]

  // op field
  localparam logic [1:0] OP_CTRL = 2'b00;  // memory / control
  localparam logic [1:0] OP_JUMP = 2'b01;  // branches
  localparam logic [1:0] OP_ALU  = 2'b10;  // arithmetic / compare
  localparam logic [1:0] OP_RSVD = 2'b11;

  // inst field, op == OP_CTRL
  localparam logic [1:0] INST_STR  = 2'b00;
  localparam logic [1:0] INST_LDR  = 2'b01;
  localparam logic [1:0] INST_NOP  = 2'b10;
  localparam logic [1:0] INST_HALT = 2'b11;

  // inst field, op == OP_JUMP
  localparam logic [1:0] INST_JMP  = 2'b00;
  localparam logic [1:0] INST_JEQ  = 2'b01;
  localparam logic [1:0] INST_JLT  = 2'b10;
  localparam logic [1:0] INST_JNV  = 2'b11;

  // inst field, op == OP_ALU
  localparam logic [1:0] INST_ADD  = 2'b00;
  localparam logic [1:0] INST_SUB  = 2'b01;
  localparam logic [1:0] INST_MUL  = 2'b10;
  localparam logic [1:0] INST_CMP  = 2'b11;

  // Jump condition codes driven by the control unit
  localparam logic [1:0] JF_ALWAYS = 2'b00;
  localparam logic [1:0] JF_EQ     = 2'b01;
  localparam logic [1:0] JF_LT     = 2'b10;
  localparam logic [1:0] JF_NEVER  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } fis_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_issue_unit_if.sv
`default_nettype none
// ============================================================================
// Interface   : fetch_issue_unit_if
// Description : Bundles the instruction-memory handshake, the issue bus to
//               the control unit/datapath and the jump/compare feedback from
//               the control unit and ALU.
//   master (fetch unit): drives imem_req, imem_addr, op, inst, flagV, instr,
//                        issue_valid; receives imem_rdata, imem_valid, stall,
//                        jmpSel, jmpF, CondEn, alu_eq, alu_lt.
//   slave  (environment): the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_issue_unit_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;
  logic               stall;
  logic [1:0]         op;
  logic [1:0]         inst;
  logic               flagV;
  logic [INSTR_W-1:0] instr;
  logic               issue_valid;
  logic               jmpSel;
  logic [1:0]         jmpF;
  logic               CondEn;
  logic               alu_eq;
  logic               alu_lt;

  modport master (
    output imem_req, imem_addr, op, inst, flagV, instr, issue_valid,
    input  imem_rdata, imem_valid, stall, jmpSel, jmpF, CondEn, alu_eq, alu_lt
  );

  modport slave (
    input  imem_req, imem_addr, op, inst, flagV, instr, issue_valid,
    output imem_rdata, imem_valid, stall, jmpSel, jmpF, CondEn, alu_eq, alu_lt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_issue_unit_jump_resolve.sv
`default_nettype none
// ============================================================================
// Module      : jump_resolve
// Description : Combinational next-PC selection for the issuing instruction.
//   jmpSel, jmpF    : jump request and condition from the control unit
//   flag_eq/flag_lt : latched compare flags (values before any update)
//   pc, target      : current PC and absolute jump target
//   next_pc         : target when taken, otherwise pc+1 (wraps)
//   taken           : jump is taken this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module jump_resolve
  import asip_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            jmpSel,
  input  logic [1:0]      jmpF,
  input  logic            flag_eq,
  input  logic            flag_lt,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] next_pc,
  output logic            taken
);

  localparam logic [PC_W-1:0] C_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic w_cond;

  always_comb begin
    w_cond = 1'b0;
    case (jmpF)
      JF_ALWAYS: w_cond = 1'b1;
      JF_EQ:     w_cond = flag_eq;
      JF_LT:     w_cond = flag_lt;
      default:   w_cond = 1'b0;  // JF_NEVER
    endcase
  end

  assign taken   = jmpSel & w_cond;
  assign next_pc = taken ? target : pc + C_ONE;

endmodule
`default_nettype wire

// File: rtl/fetch_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_issue_unit
// Description : Instruction fetch/issue front end of the vector ASIP. Owns the
//               PC, fetches over a req/valid handshake, issues op/inst/flagV/
//               instr, resolves jumps and holds the compare flags.
//   clk, rst (sync, active-low), start : control
//   bus    : fetch_issue_unit_if.master (imem handshake, issue bus,
//            control-unit jump/compare feedback)
//   pc     : current program counter
//   halted : HALT state reached (sticky until reset)
//   jmp_count : saturating taken-jump counter, present only when the
//               JMP_COUNT_EN macro is defined
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_issue_unit
  import asip_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  fetch_issue_unit_if.master  bus,
  output logic [PC_W-1:0]     pc,
  output logic                halted
`ifdef JMP_COUNT_EN
  ,
  output logic [15:0]         jmp_count
`endif
);

  fis_state_t         r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_ir, w_ir_nxt;
  logic               r_flag_eq, w_flag_eq_nxt;
  logic               r_flag_lt, w_flag_lt_nxt;

  logic               w_req;
  logic               w_issue_valid;
  logic               w_halted;
  logic               w_is_halt;
  logic               w_resolve;
  logic               w_taken;
  logic [PC_W-1:0]    w_jr_pc;

  jump_resolve #(
    .PC_W (PC_W)
  ) u_jump_resolve (
    .jmpSel  (bus.jmpSel),
    .jmpF    (bus.jmpF),
    .flag_eq (r_flag_eq),
    .flag_lt (r_flag_lt),
    .pc      (r_pc),
    .target  (r_ir[PC_W-1:0]),
    .next_pc (w_jr_pc),
    .taken   (w_taken)
  );

  assign w_is_halt = (r_ir[OP_MSB -: 2] == OP_CTRL) && (r_ir[INST_MSB -: 2] == INST_HALT);
  // An instruction resolves on the single ISSUE cycle without stall
  assign w_resolve = (r_state == S_ISSUE) && !bus.stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_flag_eq <= 1'b0;
      r_flag_lt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_flag_eq <= w_flag_eq_nxt;
      r_flag_lt <= w_flag_lt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_flag_eq_nxt = r_flag_eq;
    w_flag_lt_nxt = r_flag_lt;
    w_req         = 1'b0;
    w_issue_valid = 1'b0;
    w_halted      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        w_req = 1'b1;
        if (bus.imem_valid) begin
          w_ir_nxt    = bus.imem_rdata;
          w_state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_issue_valid = 1'b1;
        if (!bus.stall) begin
          // Flags update after resolution: jump_resolve sees the old values
          if (bus.CondEn) begin
            w_flag_eq_nxt = bus.alu_eq;
            w_flag_lt_nxt = bus.alu_lt;
          end
          if (w_is_halt) begin
            w_state_nxt = S_HALT;  // pc stays on the HALT address
          end else begin
            w_pc_nxt    = w_jr_pc;
            w_state_nxt = S_FETCH;
          end
        end
      end

      S_HALT: begin
        w_halted = 1'b1;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.issue_valid = w_issue_valid;
  assign bus.op          = r_ir[OP_MSB -: 2];
  assign bus.inst        = r_ir[INST_MSB -: 2];
  assign bus.flagV       = r_ir[FLAGV_BIT];
  assign bus.instr       = r_ir;
  assign pc              = r_pc;
  assign halted          = w_halted;

`ifdef JMP_COUNT_EN
  logic [15:0] r_jmp_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_jmp_count <= '0;
    end else if (w_resolve && w_taken && (r_jmp_count != 16'hFFFF)) begin
      r_jmp_count <= r_jmp_count + 16'd1;
    end
  end

  assign jmp_count = r_jmp_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_issue_unit
// Description : Directed self-checking bench for fetch_issue_unit. Drives the
//               imem and control-unit side of the interface by hand and
//               compares outputs against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_issue_unit;
  import asip_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pc;
  logic        halted;
`ifdef JMP_COUNT_EN
  logic [15:0] jmp_count;
  int          exp_jc = 0;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  fetch_issue_unit_if #(.INSTR_W(32), .PC_W(16)) bus ();

  fetch_issue_unit #(
    .INSTR_W (32),
    .PC_W    (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
`ifdef JMP_COUNT_EN
    ,
    .jmp_count (jmp_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clr_ctl();
    bus.jmpSel = 1'b0;
    bus.jmpF   = 2'b00;
    bus.CondEn = 1'b0;
    bus.alu_eq = 1'b0;
    bus.alu_lt = 1'b0;
  endtask

  // Starts just after an edge that entered FETCH; one wait cycle, word
  // returned, then the ISSUE cycle with the given control-unit response.
  task automatic run_instr(input logic [31:0] word, input logic js, input logic [1:0] jf,
                           input logic ce, input logic eq, input logic lt);
    step();
    bus.imem_valid = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.jmpSel = js;
    bus.jmpF   = jf;
    bus.CondEn = ce;
    bus.alu_eq = eq;
    bus.alu_lt = lt;
    step();
    clr_ctl();
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.stall      = 1'b0;
    clr_ctl();
    step();
    step();

    // Reset state
    chk("rst_pc",     32'(pc), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_req",    32'(bus.imem_req), 32'h0);
    chk("rst_ivalid", 32'(bus.issue_valid), 32'h0);
    chk("rst_instr",  bus.instr, 32'h0);
`ifdef JMP_COUNT_EN
    chk("rst_jc",     32'(jmp_count), 32'h0);
`endif

    rst = 1'b1;
    step();
    chk("idle_req", 32'(bus.imem_req), 32'h0);

    // Test 1: start, ADD with valid one cycle after req
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_req",  32'(bus.imem_req), 32'h1);
    chk("t1_addr", 32'(bus.imem_addr), 32'h0);
    chk("t1_ivalid_fetch", 32'(bus.issue_valid), 32'h0);
    step();
    chk("t1_req_hold", 32'(bus.imem_req), 32'h1);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h8000_0000;
    step();
    bus.imem_valid = 1'b0;
    chk("t1_ivalid", 32'(bus.issue_valid), 32'h1);
    chk("t1_op",     32'(bus.op), 32'h2);
    chk("t1_inst",   32'(bus.inst), 32'h0);
    chk("t1_flagv",  32'(bus.flagV), 32'h0);
    chk("t1_req_issue", 32'(bus.imem_req), 32'h0);
    step();
    chk("t1_pc",   32'(pc), 32'h1);
    chk("t1_addr1", 32'(bus.imem_addr), 32'h1);
    chk("t1_ivalid_off", 32'(bus.issue_valid), 32'h0);

    // Test 2: ADD at 1, CMP(eq=1) at 2, JEQ 0x40 at 3 -> taken
    run_instr(32'h8800_0000, 1'b0, JF_ALWAYS, 1'b0, 1'b0, 1'b0);
    chk("t2_pc2", 32'(pc), 32'h2);
    run_instr(32'hB000_0000, 1'b0, JF_ALWAYS, 1'b1, 1'b1, 1'b0);
    chk("t2_pc3", 32'(pc), 32'h3);
    run_instr(32'h5000_0040, 1'b1, JF_EQ, 1'b0, 1'b0, 1'b0);
    chk("t2_jeq_taken", 32'(pc), 32'h40);
`ifdef JMP_COUNT_EN
    exp_jc++;
`endif
    // JMP back to 2, CMP(eq=0,lt=1), JEQ not taken -> 4
    run_instr(32'h4000_0002, 1'b1, JF_ALWAYS, 1'b0, 1'b0, 1'b0);
    chk("t2_jmp", 32'(pc), 32'h2);
`ifdef JMP_COUNT_EN
    exp_jc++;
`endif
    run_instr(32'hB000_0000, 1'b0, JF_ALWAYS, 1'b1, 1'b0, 1'b1);
    run_instr(32'h5000_0040, 1'b1, JF_EQ, 1'b0, 1'b0, 1'b0);
    chk("t2_jeq_not", 32'(pc), 32'h4);
    // JLT 0x50 with flag_lt=1 -> taken
    run_instr(32'h6000_0050, 1'b1, JF_LT, 1'b0, 1'b0, 1'b0);
    chk("t2_jlt", 32'(pc), 32'h50);
`ifdef JMP_COUNT_EN
    exp_jc++;
`endif
    // JEQ with CondEn(eq=1) in the same cycle resolves on old flag_eq=0
    run_instr(32'h5000_0010, 1'b1, JF_EQ, 1'b1, 1'b1, 1'b0);
    chk("t2_preflag", 32'(pc), 32'h51);

    // Test 3: stall three cycles in ISSUE, CondEn ignored while stalled
    step();
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h8800_1234;
    step();
    bus.imem_valid = 1'b0;
    bus.stall  = 1'b1;
    bus.CondEn = 1'b1;
    bus.alu_eq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_ivalid", 32'(bus.issue_valid), 32'h1);
      chk("t3_instr",  bus.instr, 32'h8800_1234);
      chk("t3_pc",     32'(pc), 32'h51);
    end
    chk("t3_flagv", 32'(bus.flagV), 32'h1);
    bus.stall  = 1'b0;
    bus.CondEn = 1'b0;
    step();
    chk("t3_release", 32'(pc), 32'h52);
    // flag_eq must still be 1: JEQ taken
    run_instr(32'h5000_0020, 1'b1, JF_EQ, 1'b0, 1'b0, 1'b0);
    chk("t3_flag_kept", 32'(pc), 32'h20);
`ifdef JMP_COUNT_EN
    exp_jc++;
`endif

    // Test 4: wrap from 0xFFFF, then JF_NEVER
    run_instr(32'h4000_FFFF, 1'b1, JF_ALWAYS, 1'b0, 1'b0, 1'b0);
    chk("t4_pcffff", 32'(pc), 32'hFFFF);
`ifdef JMP_COUNT_EN
    exp_jc++;
`endif
    run_instr(32'h8000_0000, 1'b0, JF_ALWAYS, 1'b0, 1'b0, 1'b0);
    chk("t4_wrap", 32'(pc), 32'h0);
    run_instr(32'h7000_ABCD, 1'b1, JF_NEVER, 1'b0, 1'b0, 1'b0);
    chk("t4_never", 32'(pc), 32'h1);

    // Test 5: HALT at 1
    run_instr(32'h3000_0000, 1'b0, JF_ALWAYS, 1'b0, 1'b0, 1'b0);
    chk("t5_halted", 32'(halted), 32'h1);
    chk("t5_req",    32'(bus.imem_req), 32'h0);
    chk("t5_ivalid", 32'(bus.issue_valid), 32'h0);
    chk("t5_pc",     32'(pc), 32'h1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5_sticky", 32'(halted), 32'h1);
    chk("t5_req2",   32'(bus.imem_req), 32'h0);
    chk("t5_pc2",    32'(pc), 32'h1);
`ifdef JMP_COUNT_EN
    chk("t6_jc", 32'(jmp_count), 32'(exp_jc));
`endif
    rst = 1'b0;
    step();
    chk("t5_rst_halted", 32'(halted), 32'h0);
    chk("t5_rst_pc",     32'(pc), 32'h0);
    chk("t5_rst_instr",  bus.instr, 32'h0);
    chk("t5_rst_op",     32'(bus.op), 32'h0);
`ifdef JMP_COUNT_EN
    chk("t5_rst_jc",     32'(jmp_count), 32'h0);
`endif
    rst = 1'b1;
    step();
    chk("t5_idle_req", 32'(bus.imem_req), 32'h0);

    // Test 6: reset mid-FETCH with coincident imem_valid
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_fetch", 32'(bus.imem_req), 32'h1);
    step();
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    rst = 1'b0;
    step();
    chk("t6_ir_zero", bus.instr, 32'h0);
    chk("t6_req_off", 32'(bus.imem_req), 32'h0);
    rst = 1'b1;
    step();
    // Back in IDLE: imem_valid still high must be ignored
    chk("t6_idle_ir", bus.instr, 32'h0);
    chk("t6_idle_ivalid", 32'(bus.issue_valid), 32'h0);
    bus.imem_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_restart_req",  32'(bus.imem_req), 32'h1);
    chk("t6_restart_addr", 32'(bus.imem_addr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
